// File: rtl/adc32_pkg.sv
// Shared definitions for the sequential 32-bit add/subtract controller.
// Holds the FSM state encoding, operation codes and the default datapath sizes.
package adc32_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SLICE_W_DEF = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : adc32_pkg

// File: rtl/adc_slice.sv
// Combinational SLICE_W-bit ripple-carry adder slice.
// Ports:
//   a, b      : slice operands (b already inverted for subtract)
//   cin       : carry into bit 0
//   sum       : slice sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (for signed overflow)
module adc_slice #(
  parameter int unsigned SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb_in
);

  // Ripple the carry through a local variable, one full-adder cell per bit.
  always_comb begin
    logic carry;
    carry    = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      if (i == SLICE_W - 1) c_msb_in = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule : adc_slice

// File: rtl/adc32_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: one SLICE_W-bit slice per clock,
// LSB slice first, with the inter-slice carry held in a register.
// Optional zero flag: define ADC32_SEQ_ZERO_FLAG_EN to add output zf.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   start         : request, sampled only in IDLE
//   op_sub        : 0 = a+b, 1 = a-b; latched with start
//   a, b          : operands; latched with start
//   busy          : high in RUN and DONE
//   done          : one-cycle pulse, result valid
//   s, co, ovf    : result, carry out of MSB, signed overflow
//   zf            : (optional) result is zero
module adc32_seq_ctrl
  import adc32_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SLICE_W = SLICE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
`ifdef ADC32_SEQ_ZERO_FLAG_EN
  ,
  output logic             zf
`endif
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state_q, state_next;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic               accept;
  logic               slice_last;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;

  // Operands are shifted right each RUN cycle, so the active slice is always at the bottom.
  adc_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a        (a_q[SLICE_W-1:0]),
    .b        (b_q[SLICE_W-1:0]),
    .cin      (carry_q),
    .sum      (slice_sum),
    .cout     (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    slice_last = (idx_q == IDX_W'(NSLICE - 1));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (slice_last) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status flags track the state they will be in after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= (state_next == ST_DONE);
    end
  end

  // Operand latch, slice sequencing and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= (op_sub == OP_SUB) ? ~b : b;
      carry_q <= op_sub;               // the +1 of two's-complement subtract
      idx_q   <= '0;
      s       <= '0;
    end else if (state_q == ST_RUN) begin
      s[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
      carry_q <= slice_cout;
      a_q     <= a_q >> SLICE_W;
      b_q     <= b_q >> SLICE_W;
      idx_q   <= idx_q + IDX_W'(1);
      if (slice_last) begin
        co  <= slice_cout;
        ovf <= slice_cout ^ slice_cmsb;
      end
    end
  end

`ifdef ADC32_SEQ_ZERO_FLAG_EN
  logic acc_q;

  // OR-accumulate every slice sum; zf resolves on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
      zf    <= 1'b0;
    end else if (accept) begin
      acc_q <= 1'b0;
      zf    <= 1'b0;
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_q | (|slice_sum);
      if (slice_last) zf <= ~(acc_q | (|slice_sum));
    end
  end
`endif

endmodule : adc32_seq_ctrl

// File: doc/adc32_seq_ctrl.md
Name: adc32_seq_ctrl

Overview:
Multi-cycle sequencer for the 32-bit add/subtract datapath. It time-shares one SLICE_W-bit ripple slice adder across the operand width, one slice per clock, LSB slice first, and propagates the carry between slices in a register. It accepts operands with a start/busy handshake, returns sum, carry-out and signed overflow, and pulses done for one cycle. It sits between the ALU operand registers and the result bus, replacing a full-width adder where area matters more than latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE_W
SLICE_W, 8, bits processed per cycle; NSLICE = WIDTH/SLICE_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
op_sub  in  1  0 = A+B, 1 = A−B (two's complement); latched with start
a  in  WIDTH  operand A; latched with start
b  in  WIDTH  operand B; latched with start
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; result valid
s  out  WIDTH  result; holds until the next accepted start
co  out  1  carry out of MSB (for subtract: 1 = no borrow)
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; busy=0, done=0, s=0, co=0, ovf=0; slice index=0; carry register=0. Reset overrides everything, including mid-RUN; the partial result is discarded.
- FSM:
  - IDLE: start=1 at edge E0 latches a, b (b inverted if op_sub), op_sub and carry=op_sub; clears s; idx=0; goes to RUN.
  - RUN: each edge adds slice idx of A and B' with the carry register; writes s[idx*SLICE_W +: SLICE_W]; registers the slice carry-out; idx++. On the edge that processes idx=NSLICE−1, it also captures co and ovf from the slice's MSB carries and goes to DONE.
  - DONE: done=1 for exactly this one cycle; next edge returns to IDLE.
- Latency: done is high during the cycle after edge E0+NSLICE (NSLICE=4 at the defaults). Throughput is one operation per NSLICE+2 cycles.
- start outside IDLE (RUN/DONE) is ignored and not queued. The a/b/op_sub inputs may change freely after E0.
- s updates slice by slice during RUN; it is only guaranteed valid from done onward.
- Arithmetic: modulo 2^WIDTH. Subtract is A + ~B + 1. Example: 0 − 1 → s=FFFFFFFF, co=0.
- rst and start asserted on the same edge: reset wins and the start is dropped.

Optional Feature:
- Macro ADC32_SEQ_ZERO_FLAG_EN.
- Defined: adds output port zf (1 bit). zf is an OR-accumulator of the slice-sum bits, cleared at start. zf=1 iff the final s==0. It is valid with done and held with s; reset value 0.
- Undefined: no zf port and no accumulator logic. All other behaviour is identical.

Decomposition:
- Shared package adc32_pkg holds:
  - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - OP_ADD=1'b0, OP_SUB=1'b1
  - default WIDTH/SLICE_W constants
- One sub-module, adc_slice: combinational SLICE_W-bit ripple of the existing add cell. Inputs: slice of A, slice of B', cin. Outputs: sum, cout, c_msb_in (carry into the top bit, used for ovf).
- The controller holds the FSM, index counter, carry register and result register.

Test Plan:
1. rst=1 for 2 cycles, then 0 → busy=0, done=0, s=0, co=0, ovf=0.
2. start with a=0x0000_00FF, b=0x0000_0001, op_sub=0 → done exactly 4 cycles after the accept edge; s=0x0000_0100, co=0, ovf=0. The carry crosses the slice 0→1 boundary.
3. a=0xFFFF_FFFF, b=0x0000_0001, add → s=0, co=1, ovf=0, zf=1 if enabled. Then a=0x7FFF_FFFF, b=1, add → s=0x8000_0000, co=0, ovf=1.
4. Subtract a=0, b=1 → s=0xFFFF_FFFF, co=0, ovf=0. Subtract a=0x8000_0000, b=1 → s=0x7FFF_FFFF, co=1, ovf=1.
5. Pulse start again at the 2nd RUN cycle and during DONE → ignored; exactly one done pulse; result is unchanged from the first operation.
6. Assert rst during the 3rd RUN cycle → the next cycle is IDLE with all outputs 0. A following start completes normally with the correct sum.
